bitreverse_reorder: RTL and testbench
=====================================

Name: bitreverse_reorder

Overview:
- Final block of the single-sample-per-clock FFT pipeline; sits directly downstream of the last butterfly stage.
- The FFT output arrives in bit-reversed index order. This block buffers it and re-emits each frame in natural order (X[0]..X[N-1]).
- Uses a ping-pong memory of 2*N words. One bank is written in arrival order while the other bank is read at bit-reversed addresses.
- Shares the pipeline's i_clk_enable / i_sync / o_sync framing.

Parameters:
- LGSIZE, 12, log2 of FFT length N (N = 2^LGSIZE).
- WIDTH, 34, complex sample width: {real, imag} packed, real in upper half; equals 2*OWIDTH of the upstream stage.

Ports:
- i_clk  input  1  clock
- i_reset  input  1  reset
- i_clk_enable  input  1  qualifies every state/data update; nothing changes when low
- i_sync  input  1  high with the first sample of an input frame
- i_in  input  WIDTH  complex input sample, bit-reversed order
- o_out  output  WIDTH  complex output sample, natural order
- o_sync  output  1  high with the first sample (X[0]) of each output frame

Behaviour:
- Reset: i_reset is synchronous, active-high; clock is i_clk. Reset values:
  - o_out=0, o_sync=0
  - write counter wr_cnt (LGSIZE+1 bits) = 0
  - wait_for_sync=1, started=0
  - memory contents are not reset.
- All register updates occur only on cycles with i_clk_enable=1 (an "enable cycle"). With enable low, every register, including o_out and o_sync, holds its value.
- Lock:
  - While wait_for_sync=1, wr_cnt stays 0 and nothing is written.
  - On the first enable cycle with i_sync=1: write i_in, clear wait_for_sync, wr_cnt becomes 1.
  - Once locked, wr_cnt increments on every enable cycle and wraps modulo 2N.
- Write: on each locked enable cycle, mem[bank=wr_cnt[LGSIZE]][addr=wr_cnt[LGSIZE-1:0]] <= i_in.
- Read:
  - On the same enable cycle, o_out <= mem[~wr_cnt[LGSIZE]][bitrev(wr_cnt[LGSIZE-1:0])].
  - bitrev reverses the LGSIZE address bits.
  - Read and write always target opposite banks, so there is no read/write collision.
- started:
  - Set on the enable cycle that writes index N-1 of the first locked frame (wr_cnt transitions to N).
  - Stays set until reset.
  - While started=0, o_out is forced to 0 and o_sync to 0.
- o_sync <= started && (wr_cnt[LGSIZE-1:0]==0) && !wait_for_sync, registered alongside o_out.
- Latency:
  - Count the sync enable cycle as E0.
  - Output sample X[k] of frame f is registered on enable cycle E0 + N*(f+1) + k.
  - It is visible after that edge, i.e. N enable cycles from input to output.
  - Throughput is one sample per enable cycle with no gaps, continuously.
- i_sync after lock is ignored. The framing is free-running; only i_reset re-arms the sync search.
- Reset mid-frame:
  - Outputs return to 0 on the next edge.
  - Buffered data is discarded logically: started is cleared, so stale memory is never emitted.
  - A new i_sync is required.
- Memory is inferred as block RAM: one write port and one registered read port per cycle.

Test Plan:
All scenarios use LGSIZE=3 (N=8), WIDTH=34. Input value = running sample index.

1. Reset, then 20 enable cycles with i_sync=0 and random i_in -> o_out=0 and o_sync=0 throughout.
2. i_sync with sample 0, feed 0..15 contiguously -> o_sync=1 after the 9th enable edge (E8) only. o_out sequence from E8 = 0,4,2,6,1,5,3,7.
3. Continuous stream of 0..39 -> next frames emerge as 8,12,10,14,9,13,11,15, then 16,20,18,22,17,21,19,23, etc. o_sync pulses every 8 enables, aligned to 8, 16, 24.
4. Repeat scenario 3 with i_clk_enable randomly low about 40% of cycles -> identical output sequence over enabled cycles. o_out and o_sync hold their values on disabled cycles.
5. Extra i_sync pulses at sample indices 3 and 13 -> output sequence unchanged from scenario 3.
6. Assert i_reset at sample 11 -> o_out=0 and o_sync=0 from the next edge. No output until a new i_sync; the post-reset frame 100..107 emerges as 100,104,102,106,101,105,103,107.

Source files
------------

// File: rtl/bitreverse_reorder.sv
// Purpose: reorders one FFT frame from bit-reversed arrival order into natural order (X[0]..X[N-1]).
// Latency: N enable cycles from input sample to output sample; one sample per enable cycle, no gaps.
// Backpressure: none; i_clk_enable stalls the whole block, and every register holds while it is low.
//
// Ports:
//   i_clk, i_reset   clock and synchronous active-high reset
//   i_clk_enable     qualifies every state and data update
//   i_sync           marks the first sample of an input frame (only the first one after reset matters)
//   i_in             complex sample {real, imag}, bit-reversed order
//   o_out            complex sample, natural order (zero until the first frame is fully buffered)
//   o_sync           high with X[0] of each output frame
//
// A ping-pong memory of 2*N words is used: the bank selected by wr_cnt[LGSIZE] is written in
// arrival order while the opposite bank is read at bit-reversed addresses.
module bitreverse_reorder #(
    parameter int LGSIZE = 12,
    parameter int WIDTH  = 34
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clk_enable,
    input  logic             i_sync,
    input  logic [WIDTH-1:0] i_in,
    output logic [WIDTH-1:0] o_out,
    output logic             o_sync
);

    localparam int N = 1 << LGSIZE;
    localparam logic [LGSIZE:0] FILL_LAST = (LGSIZE+1)'(N - 1);

    // S_WAIT: searching for i_sync. S_FILL: first frame being written, nothing valid to read yet.
    // S_RUN: free-running, the opposite bank always holds a complete frame.
    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [LGSIZE:0]   wr_cnt_q, wr_cnt_d;
    logic              out_vld_q, out_vld_d;
    logic              sync_q, sync_d;
    logic              wr_en;
    logic [LGSIZE-1:0] rd_lo;
    logic [LGSIZE:0]   rd_addr;
    logic [WIDTH-1:0]  rd_dat_q;

    logic [WIDTH-1:0]  mem [0:2*N-1];

    // Read address: opposite bank, bit-reversed offset of the current write position.
    always_comb begin
        rd_lo = '0;
        for (int b = 0; b < LGSIZE; b++) begin
            rd_lo[b] = wr_cnt_q[LGSIZE-1-b];
        end
        rd_addr = {~wr_cnt_q[LGSIZE], rd_lo};
    end

    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        wr_en     = 1'b0;
        // The read issued this cycle is only meaningful once a full frame sits in the other bank.
        out_vld_d = (state_q == S_RUN);
        sync_d    = (state_q == S_RUN) && (wr_cnt_q[LGSIZE-1:0] == '0);
        case (state_q)
            S_WAIT: begin
                if (i_sync) begin
                    wr_en    = 1'b1;
                    wr_cnt_d = (LGSIZE+1)'(1);
                    state_d  = S_FILL;
                end
            end
            S_FILL: begin
                wr_en    = 1'b1;
                wr_cnt_d = wr_cnt_q + 1'b1;
                if (wr_cnt_q == FILL_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // i_sync is deliberately ignored here: framing is free-running until reset.
                wr_en    = 1'b1;
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
            default: begin
                state_d  = S_WAIT;
                wr_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= S_WAIT;
            wr_cnt_q  <= '0;
            out_vld_q <= 1'b0;
            sync_q    <= 1'b0;
        end else if (i_clk_enable) begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            out_vld_q <= out_vld_d;
            sync_q    <= sync_d;
        end
    end

    // Plain one-write/one-registered-read memory so it maps onto block RAM; no reset on the
    // array or its read register, stale contents are masked by out_vld_q instead.
    always_ff @(posedge i_clk) begin
        if (i_clk_enable && !i_reset) begin
            if (wr_en) begin
                mem[wr_cnt_q] <= i_in;
            end
            rd_dat_q <= mem[rd_addr];
        end
    end

    assign o_out  = out_vld_q ? rd_dat_q : '0;
    assign o_sync = sync_q;

endmodule

// File: tb/tb_bitreverse_reorder.sv
// Purpose: directed self-checking bench for bitreverse_reorder with N=8.
// Latency: expects X[k] of frame f on enable edge E0 + 8*(f+1) + k.
// Backpressure: exercises random i_clk_enable gaps, outputs must hold while disabled.
module tb_bitreverse_reorder;

    localparam int LGSIZE = 3;
    localparam int WIDTH  = 34;
    localparam int N      = 8;

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic             i_clk_enable;
    logic             i_sync;
    logic [WIDTH-1:0] i_in;
    logic [WIDTH-1:0] o_out;
    logic             o_sync;

    int checks = 0;
    int errors = 0;

    // 3-bit bit reversal, written out by hand.
    int brv [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    bitreverse_reorder #(
        .LGSIZE(LGSIZE),
        .WIDTH (WIDTH)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clk_enable(i_clk_enable),
        .i_sync      (i_sync),
        .i_in        (i_in),
        .o_out       (o_out),
        .o_sync      (o_sync)
    );

    always #5 i_clk = ~i_clk;

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic rst, input logic en, input logic sy, input logic [WIDTH-1:0] din);
        i_reset      = rst;
        i_clk_enable = en;
        i_sync       = sy;
        i_in         = din;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
    endtask

    // Expected o_out after the enable edge of stream position j (j=0 is the sync sample),
    // when sample j carries value base+j.
    function automatic logic [WIDTH-1:0] exp_out(int j, int base);
        if (j < N) return '0;
        return WIDTH'(base + N * (j / N - 1) + brv[j % N]);
    endfunction

    function automatic logic exp_sync(int j);
        return (j >= N) && (j % N == 0);
    endfunction

    task automatic test_reset();
        logic [WIDTH-1:0] rnd;
        do_reset();
        checks++;
        if (o_out !== '0 || o_sync !== 1'b0) begin
            errors++;
            $display("FAIL reset_state out=%0h sync=%b required out=0 sync=0", o_out, o_sync);
        end
        for (int c = 0; c < 20; c++) begin
            rnd = WIDTH'({$urandom(), $urandom()});
            step(1'b0, 1'b1, 1'b0, rnd);
            checks++;
            if (o_out !== '0 || o_sync !== 1'b0) begin
                errors++;
                $display("FAIL no_sync c=%0d out=%0h sync=%b required out=0 sync=0", c, o_out, o_sync);
            end
        end
    endtask

    task automatic test_first_frame();
        do_reset();
        for (int j = 0; j < 16; j++) begin
            step(1'b0, 1'b1, j == 0, WIDTH'(j));
            checks++;
            if (o_out !== exp_out(j, 0) || o_sync !== (j == 8)) begin
                errors++;
                $display("FAIL first_frame j=%0d out=%0d sync=%b required out=%0d sync=%b",
                         j, o_out, o_sync, exp_out(j, 0), (j == 8));
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int j = 0; j < 40; j++) begin
            step(1'b0, 1'b1, j == 0, WIDTH'(j));
            checks++;
            if (o_out !== exp_out(j, 0) || o_sync !== exp_sync(j)) begin
                errors++;
                $display("FAIL back_to_back j=%0d out=%0d sync=%b required out=%0d sync=%b",
                         j, o_out, o_sync, exp_out(j, 0), exp_sync(j));
            end
        end
    endtask

    task automatic test_enable_gaps();
        int               j      = 0;
        int               cycles = 0;
        logic             en;
        logic [WIDTH-1:0] hold_out  = '0;
        logic             hold_sync = 1'b0;
        do_reset();
        while (j < 40 && cycles < 400) begin
            en = ($urandom_range(0, 99) >= 40);
            step(1'b0, en, j == 0, WIDTH'(j));
            cycles++;
            if (en) begin
                checks++;
                if (o_out !== exp_out(j, 0) || o_sync !== exp_sync(j)) begin
                    errors++;
                    $display("FAIL enable_gaps j=%0d out=%0d sync=%b required out=%0d sync=%b",
                             j, o_out, o_sync, exp_out(j, 0), exp_sync(j));
                end
                hold_out  = exp_out(j, 0);
                hold_sync = exp_sync(j);
                j++;
            end else begin
                checks++;
                if (o_out !== hold_out || o_sync !== hold_sync) begin
                    errors++;
                    $display("FAIL enable_hold j=%0d out=%0d sync=%b required out=%0d sync=%b",
                             j, o_out, o_sync, hold_out, hold_sync);
                end
            end
        end
        checks++;
        if (j < 40) begin
            errors++;
            $display("FAIL enable_budget fed=%0d required=40", j);
        end
    endtask

    task automatic test_extra_sync();
        do_reset();
        for (int j = 0; j < 40; j++) begin
            step(1'b0, 1'b1, (j == 0) || (j == 3) || (j == 13), WIDTH'(j));
            checks++;
            if (o_out !== exp_out(j, 0) || o_sync !== exp_sync(j)) begin
                errors++;
                $display("FAIL extra_sync j=%0d out=%0d sync=%b required out=%0d sync=%b",
                         j, o_out, o_sync, exp_out(j, 0), exp_sync(j));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        for (int j = 0; j < 11; j++) begin
            step(1'b0, 1'b1, j == 0, WIDTH'(j));
            checks++;
            if (o_out !== exp_out(j, 0) || o_sync !== exp_sync(j)) begin
                errors++;
                $display("FAIL pre_reset j=%0d out=%0d sync=%b required out=%0d sync=%b",
                         j, o_out, o_sync, exp_out(j, 0), exp_sync(j));
            end
        end
        step(1'b1, 1'b1, 1'b0, WIDTH'(11));
        checks++;
        if (o_out !== '0 || o_sync !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset out=%0d sync=%b required out=0 sync=0", o_out, o_sync);
        end
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 1'b1, 1'b0, WIDTH'(12 + c));
            checks++;
            if (o_out !== '0 || o_sync !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle c=%0d out=%0d sync=%b required out=0 sync=0",
                         c, o_out, o_sync);
            end
        end
        for (int j = 0; j < 16; j++) begin
            step(1'b0, 1'b1, j == 0, WIDTH'(100 + j));
            checks++;
            if (o_out !== exp_out(j, 100) || o_sync !== (j == 8)) begin
                errors++;
                $display("FAIL post_reset_frame j=%0d out=%0d sync=%b required out=%0d sync=%b",
                         j, o_out, o_sync, exp_out(j, 100), (j == 8));
            end
        end
    endtask

    initial begin
        i_reset      = 1'b1;
        i_clk_enable = 1'b0;
        i_sync       = 1'b0;
        i_in         = '0;
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_enable_gaps();
        test_extra_sync();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
